// File: rtl/grant_dec_pkg.sv
// Shared constants for the registered 2:4 grant decoder: index/line widths and FSM state codes.
package grant_dec_pkg;

    localparam int unsigned IDX_W   = 2;
    localparam int unsigned N_LINES = 4;

    // State enumeration {IDLE, GRANT, GAP}, kept as plain constants for legacy tools
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

endpackage

// File: rtl/dec_2_4.sv
// Combinational 2:4 one-hot decoder with enable; all-zero output when disabled.
module dec_2_4
    import grant_dec_pkg::*;
(
    input  logic               en,
    input  logic [IDX_W-1:0]   idx,
    output logic [N_LINES-1:0] onehot_c
);

    always_comb begin
        onehot_c = '0;
        if (en) begin
            onehot_c[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/grant_dec_2_4.sv
// Registered 2:4 grant decoder with valid/ready intake, ack release, one-cycle gap and grant counter.
// Optional forced release after TIMEOUT grant cycles when GRANT_TIMEOUT_EN is defined.
module grant_dec_2_4
    import grant_dec_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IDX_W-1:0]   in_idx,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [N_LINES-1:0] grant,
    input  logic               ack,
    output logic [CNT_W-1:0]   grant_cnt,
    output logic               timeout
);

    logic [1:0]         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               in_ready_q, in_ready_d;
    logic [N_LINES-1:0] grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
    logic               expire_c;

`ifdef GRANT_TIMEOUT_EN
    localparam int unsigned TMR_W = 16;

    logic [TMR_W-1:0] timer_q, timer_d;

    // Timer is zero on entry to GRANT and counts completed grant cycles
    always_comb begin
        timer_d  = '0;
        if (state_q == GRANT) begin
            timer_d = timer_q + TMR_W'(1);
        end
        expire_c = (state_q == GRANT) && !ack && (timer_q == TMR_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    assign expire_c = 1'b0;
`endif

    // Next state; outputs are derived from the next state so they register with it
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d = GRANT;
                    idx_d   = in_idx;
                end
            end
            GRANT: begin
                if (ack || expire_c) begin
                    state_d   = GAP;
                    cnt_d     = cnt_q + CNT_W'(1);
                    timeout_d = expire_c;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    dec_2_4 u_dec (
        .en       (state_d == GRANT),
        .idx      (idx_d),
        .onehot_c (grant_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            in_ready_q <= 1'b1;
            grant_q    <= '0;
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            in_ready_q <= in_ready_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign grant     = grant_q;
    assign grant_cnt = cnt_q;
    assign timeout   = timeout_q;

endmodule
